// File: rtl/sys_pkg.sv
// Shared constants and state encoding for the systolic array and its input sequencer.
package sys_pkg;

    localparam int N         = 9;
    localparam int W         = 32;
    localparam int PE_LAT    = 1;
    localparam int DRAIN_CYC = 2 * N + PE_LAT - 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register that skews one array lane; clears to zero on reset.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/systolic_sequencer.sv
// Feeds K beats of A columns / B rows into an NxN output-stationary array with
// diagonal skew, then drains the pipeline and strobes the result capture.
module systolic_sequencer #(
    parameter int N      = sys_pkg::N,
    parameter int W      = sys_pkg::W,
    parameter int PE_LAT = sys_pkg::PE_LAT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [7:0]     k_len,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_a,
    input  logic [N*W-1:0] in_b,
    output logic [N*W-1:0] arr_west,
    output logic [N*W-1:0] arr_north,
    output logic           arr_load,
    output logic           pe_rst_n,
    output logic           busy,
    output logic           done
);

    import sys_pkg::*;

    // Last product reaches PE(N-1,N-1) 2N-1 cycles after its beat, plus the MAC latency.
    localparam logic [7:0] DRAIN_LEN = 8'(2 * N + PE_LAT - 1);

    state_t     r_state, w_nxt;
    logic [7:0] r_beat_cnt, w_beat_nxt;
    logic [7:0] r_drain_cnt, w_drain_nxt;
    logic [7:0] r_k_len, w_k_nxt;
    logic       r_in_ready, r_arr_load, r_busy, r_done, r_pe_term;
    logic       w_accept;

    assign w_accept = in_valid & r_in_ready;

    always_comb begin
        w_nxt       = r_state;
        w_beat_nxt  = r_beat_cnt;
        w_drain_nxt = r_drain_cnt;
        w_k_nxt     = r_k_len;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nxt       = CLEAR;
                    w_k_nxt     = k_len;
                    w_beat_nxt  = '0;
                    w_drain_nxt = '0;
                end
            end
            CLEAR: w_nxt = FEED;
            FEED: begin
                if (w_accept) begin
                    w_beat_nxt = r_beat_cnt + 8'd1;
                    if (({1'b0, r_beat_cnt} + 9'd1) == {1'b0, r_k_len}) w_nxt = DRAIN;
                end else if (r_k_len == 8'd0) begin
                    w_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == DRAIN_LEN - 8'd1) begin
                    w_nxt       = CAPTURE;
                    w_drain_nxt = '0;
                end else begin
                    w_drain_nxt = r_drain_cnt + 8'd1;
                end
            end
            CAPTURE: w_nxt = DONE;
            DONE:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_k_len     <= '0;
            r_in_ready  <= 1'b0;
            r_arr_load  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pe_term   <= 1'b1;
        end else begin
            r_state     <= w_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_k_len     <= w_k_nxt;
            r_in_ready  <= (w_nxt == FEED) && (w_beat_nxt < w_k_nxt);
            r_arr_load  <= (w_nxt == CAPTURE);
            r_busy      <= (w_nxt != IDLE);
            r_done      <= (w_nxt == DONE);
            r_pe_term   <= (w_nxt != CLEAR);
        end
    end

    assign in_ready = r_in_ready;
    assign arr_load = r_arr_load;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pe_rst_n = reset & r_pe_term;

    // Lane i is delayed i+1 cycles; non-accepting cycles inject zero bubbles.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] w_a_in, w_b_in;

        assign w_a_in = w_accept ? in_a[W*(N-i)-1 -: W] : '0;
        assign w_b_in = w_accept ? in_b[W*(N-i)-1 -: W] : '0;

        skew_delay_line #(.DEPTH(i + 1), .W(W)) u_west (
            .clk   (clk),
            .reset (reset),
            .i_d   (w_a_in),
            .o_q   (arr_west[W*(N-i)-1 -: W])
        );

        skew_delay_line #(.DEPTH(i + 1), .W(W)) u_north (
            .clk   (clk),
            .reset (reset),
            .i_d   (w_b_in),
            .o_q   (arr_north[W*(N-i)-1 -: W])
        );
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer with a behavioural output-stationary array
// driven from the DUT's skewed lanes and a queue of expected load/done cycles.
module tb_systolic_sequencer;

    localparam int N     = 9;
    localparam int W     = 32;
    localparam int DRAIN = 18;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [7:0]     k_len;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_a, in_b;
    logic [N*W-1:0] arr_west, arr_north;
    logic           arr_load, pe_rst_n, busy, done;

    systolic_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .arr_west  (arr_west),
        .arr_north (arr_north),
        .arr_load  (arr_load),
        .pe_rst_n  (pe_rst_n),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed { int ld; int dn; } exp_t;
    exp_t exp_q[$];

    logic [W-1:0]   exp_c [N][N];
    logic [W-1:0]   acc   [N][N];
    logic [N*W-1:0] hin_a [16];
    logic [N*W-1:0] hin_b [16];
    logic [N*W-1:0] ow    [16];
    logic [N*W-1:0] on    [16];

    task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] lane(input logic [N*W-1:0] v, input int i);
        return v[W*(N-i)-1 -: W];
    endfunction

    function automatic logic [W-1:0] a_elem(input int kk, input int i, input int mode);
        if (mode == 1) return 1;
        return (i == kk) ? 1 : 0;
    endfunction

    function automatic logic [W-1:0] b_elem(input int kk, input int j, input int mode);
        if (mode == 1) return 1;
        return W'(N * kk + j);
    endfunction

    function automatic logic [N*W-1:0] pack_a(input int kk, input int mode);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[W*(N-i)-1 -: W] = a_elem(kk, i, mode);
        return v;
    endfunction

    function automatic logic [N*W-1:0] pack_b(input int kk, input int mode);
        logic [N*W-1:0] v;
        for (int j = 0; j < N; j++) v[W*(N-j)-1 -: W] = b_elem(kk, j, mode);
        return v;
    endfunction

    // Monitor: lane skew, array model, load/done timing against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            for (int t = 0; t < 16; t++) begin
                hin_a[t] = '0; hin_b[t] = '0; ow[t] = '0; on[t] = '0;
            end
            for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = '0;
        end else begin
            logic [N*W-1:0] ew, en;
            for (int i = 0; i < N; i++) begin
                ew[W*(N-i)-1 -: W] = lane(hin_a[(cyc - 1 - i) & 15], i);
                en[W*(N-i)-1 -: W] = lane(hin_b[(cyc - 1 - i) & 15], i);
            end
            check("arr_west", arr_west, ew);
            check("arr_north", arr_north, en);
            if (arr_load) begin
                if (exp_q.size() == 0) check("load_unexpected", 1, 0);
                else check("load_cycle", cyc, exp_q[0].ld);
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) check($sformatf("c[%0d][%0d]", i, j), acc[i][j], exp_c[i][j]);
            end
            if (done) begin
                if (exp_q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    check("done_cycle", cyc, exp_q[0].dn);
                    void'(exp_q.pop_front());
                end
            end
            hin_a[cyc & 15] = (in_valid && in_ready) ? in_a : '0;
            hin_b[cyc & 15] = (in_valid && in_ready) ? in_b : '0;
            ow[cyc & 15] = arr_west;
            on[cyc & 15] = arr_north;
            if (!pe_rst_n) begin
                for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = '0;
            end else begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        acc[i][j] = acc[i][j] + lane(ow[(cyc - j) & 15], i) * lane(on[(cyc - i) & 15], j);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_west"}, arr_west, '0);
        check({tag, "_north"}, arr_north, '0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_load"}, arr_load, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pe_rst_n"}, pe_rst_n, 0);
    endtask

    task automatic run_job(input int k, input int mode, input bit alt, input bit poke, input int abort_at);
        int  base, beat, feed, load_off;
        bit  acc_b;
        feed     = (k == 0) ? 1 : (alt ? 2 * k - 1 : k);
        load_off = 2 + feed + DRAIN;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                logic [W-1:0] s = '0;
                for (int kk = 0; kk < k; kk++) s = s + a_elem(kk, i, mode) * b_elem(kk, j, mode);
                exp_c[i][j] = s;
            end
        @(posedge clk); #1;
        base = cyc;
        beat = 0;
        exp_q.push_back('{ld: base + load_off, dn: base + load_off + 1});
        start    = 1'b1;
        k_len    = 8'(k);
        in_valid = !alt;
        in_a     = pack_a(0, mode);
        in_b     = pack_b(0, mode);
        for (int r = 1; r <= load_off + 3; r++) begin
            @(negedge clk);
            acc_b = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc_b) beat++;
            start = 1'b0;
            k_len = 8'(k);
            if (poke && (r == 5 || r == 15)) begin
                start = 1'b1;
                k_len = 8'd3;
            end
            if (r == 1) check("busy_in_job", busy, 1);
            in_valid = alt ? (r >= 2 && r % 2 == 0) : 1'b1;
            in_a     = pack_a(beat, mode);
            in_b     = pack_b(beat, mode);
            if (r == abort_at) begin
                reset = 1'b0;
                #1;
                check_reset_outputs("abort");
                exp_q.delete();
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check("beats_accepted", beat, k);
        check("busy_after_job", busy, 0);
        check("job_completed", exp_q.size(), 0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        k_len    = 8'd0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        #12;
        check_reset_outputs("reset");
        #10 reset = 1'b1;
        @(posedge clk); #1;
        check("idle_pe_rst_n", pe_rst_n, 1);

        run_job(9, 0, 1'b0, 1'b0, -1);    // identity A, full-rate feed
        run_job(9, 0, 1'b1, 1'b0, -1);    // alternate-cycle valid
        run_job(0, 0, 1'b0, 1'b0, -1);    // empty job
        run_job(9, 0, 1'b0, 1'b1, -1);    // start pokes while busy

        run_job(9, 0, 1'b0, 1'b0, 15);    // abort mid-drain
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (25) @(posedge clk);
        #1 check("abort_no_done_pending", exp_q.size(), 0);
        run_job(9, 0, 1'b0, 1'b0, -1);

        run_job(255, 1, 1'b0, 1'b0, -1);  // all ones, longest K

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
